crypto_decrypt_host: RTL and testbench

//  Iterative 128-bit block decryptor; the receive-side counterpart of the crypto encrypt host.

---
 rtl/crypto_decrypt_host.sv | 238 +++++++++++++++++++++++
 tb/tb_crypto_decrypt_host.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_decrypt_host.sv
// ---------------------------------------------------------------------------
// crypto_decrypt_host
//
// Iterative 128-bit block decryptor, the receive-side counterpart of the
// crypto encrypt host. One block is accepted at a time. The block runs
// CRYPTO_ROUNDS inverse rounds, three clock cycles per round
// (INV_MIX -> INV_SUB -> ADD_KEY). The recovered plaintext is returned with a
// single-cycle done pulse.
//
// The forward cipher applies, for each round r = 0..R-1:
//   s ^= rk(r); byte0 nibbles through SB; s = MIX_mode(s, r)
// It then applies a final whitening step with rk(15). This block undoes those
// steps in reverse order. The whitening key is removed while the block is
// being accepted, so the first clocked round is round R-1.
//
// Round key: rk(i) = key_q ^ ({4{CRYPTO_PATTERN[31:0]}} >> (8*i))
//
// Ports
//   clk            in   1    single clock, all logic on posedge
//   rst            in   1    synchronous active-high reset, aborts any block
//   ciphertext     in   128  block to decrypt, sampled on accepted start
//   key            in   128  cipher key, sampled on accepted start
//   crypto_mode    in   2    0=xor-mix 1=rotate 2=add-const 3=invert
//   decrypt_start  in   1    request, only looked at while idle
//   plaintext      out  128  result, held until the next completion
//   decrypt_done   out  1    one-cycle pulse, plaintext valid in that cycle
//   busy           out  1    high from the cycle after acceptance through
//                            the done cycle
// ---------------------------------------------------------------------------
module crypto_decrypt_host #(
  parameter int unsigned CRYPTO_ROUNDS  = 16,
  parameter logic [87:0] CRYPTO_PATTERN = 88'h123456789ABCDEF0123456,
  parameter logic [15:0] ROUND_CONST    = 16'h9E37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  input  logic [1:0]   crypto_mode,
  input  logic         decrypt_start,
  output logic [127:0] plaintext,
  output logic         decrypt_done,
  output logic         busy
);

  // Index of the first inverse round executed after acceptance.
  localparam logic [3:0]   LAST_ROUND    = 4'(CRYPTO_ROUNDS - 1);
  // Only the low 32 bits of the pattern feed the key schedule.
  localparam logic [127:0] ROUND_PATTERN = {4{CRYPTO_PATTERN[31:0]}};
  localparam logic [3:0]   WHITEN_INDEX  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INV_MIX = 2'd1,
    ST_INV_SUB = 2'd2,
    ST_ADD_KEY = 2'd3
  } fsm_t;

  // -------------------------------------------------------------------------
  // Cipher helper functions
  // -------------------------------------------------------------------------

  // Round key for a 4-bit round index. The pattern shift is 8 bits per round.
  function automatic logic [127:0] round_key(input logic [127:0] k,
                                             input logic [3:0]   idx);
    return k ^ (ROUND_PATTERN >> {idx, 3'b000});
  endfunction

  // Inverse of the 4-bit S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0:    r = 4'h5;
      4'h1:    r = 4'hE;
      4'h2:    r = 4'hF;
      4'h3:    r = 4'h8;
      4'h4:    r = 4'hC;
      4'h5:    r = 4'h1;
      4'h6:    r = 4'h2;
      4'h7:    r = 4'hD;
      4'h8:    r = 4'hB;
      4'h9:    r = 4'h4;
      4'hA:    r = 4'h6;
      4'hB:    r = 4'h3;
      4'hC:    r = 4'h0;
      4'hD:    r = 4'h7;
      4'hE:    r = 4'h9;
      4'hF:    r = 4'hA;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Only byte 0 is substituted. The remaining 120 bits pass through.
  function automatic logic [127:0] inv_sub_byte(input logic [127:0] s);
    return {s[127:8], inv_sbox(s[7:4]), inv_sbox(s[3:0])};
  endfunction

  // Undo the per-round mixing step selected by the latched mode.
  function automatic logic [127:0] inv_mix(input logic [127:0] s,
                                           input logic [1:0]   m,
                                           input logic [15:0]  rk_low);
    logic [127:0] r;
    case (m)
      2'd0:    r = s ^ {112'd0, rk_low};
      2'd1:    r = {s[0], s[127:1]};
      2'd2:    r = s - {112'd0, ROUND_CONST};
      2'd3:    r = ~s;
      default: r = s;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Registers and next-state signals
  // -------------------------------------------------------------------------
  fsm_t         fsm_r,       fsm_next_s;
  logic [127:0] data_r,      data_next_s;
  logic [127:0] key_r,       key_next_s;
  logic [1:0]   mode_r,      mode_next_s;
  logic [3:0]   round_r,     round_next_s;
  logic [127:0] plaintext_r, plaintext_next_s;
  logic         done_r,      done_next_s;
  logic         busy_r,      busy_next_s;
  logic [127:0] rk_cur_s;
  logic         last_round_s;

  // Key for the round currently in flight, and the flag for the final round.
  always_comb begin
    rk_cur_s     = round_key(key_r, round_r);
    last_round_s = (round_r == 4'd0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r <= ST_IDLE;
    end else begin
      fsm_r <= fsm_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (decrypt_start) begin
          fsm_next_s = ST_INV_MIX;
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_INV_MIX: fsm_next_s = ST_INV_SUB;
      ST_INV_SUB: fsm_next_s = ST_ADD_KEY;
      ST_ADD_KEY: begin
        // The counter stops at zero. Round 0 always finishes the block.
        if (last_round_s) begin
          fsm_next_s = ST_IDLE;
        end else begin
          fsm_next_s = ST_INV_MIX;
        end
      end
      default: fsm_next_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values for each FSM state.
  always_comb begin
    data_next_s      = data_r;
    key_next_s       = key_r;
    mode_next_s      = mode_r;
    round_next_s     = round_r;
    plaintext_next_s = plaintext_r;
    done_next_s      = 1'b0;
    busy_next_s      = busy_r;
    case (fsm_r)
      ST_IDLE: begin
        if (decrypt_start) begin
          // Whitening is removed with the live key, because key_r is only
          // loaded at this same edge.
          key_next_s   = key;
          mode_next_s  = crypto_mode;
          data_next_s  = ciphertext ^ round_key(key, WHITEN_INDEX);
          round_next_s = LAST_ROUND;
          busy_next_s  = 1'b1;
        end else begin
          busy_next_s  = 1'b0;
        end
      end
      ST_INV_MIX: begin
        data_next_s = inv_mix(data_r, mode_r, rk_cur_s[15:0]);
      end
      ST_INV_SUB: begin
        data_next_s = inv_sub_byte(data_r);
      end
      ST_ADD_KEY: begin
        data_next_s = data_r ^ rk_cur_s;
        if (last_round_s) begin
          // busy stays high through the done cycle. IDLE clears it next.
          plaintext_next_s = data_r ^ rk_cur_s;
          done_next_s      = 1'b1;
        end else begin
          round_next_s     = round_r - 4'd1;
        end
      end
      default: begin
        data_next_s = data_r;
      end
    endcase
  end

  // Datapath and output registers. Reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r      <= 128'd0;
      key_r       <= 128'd0;
      mode_r      <= 2'd0;
      round_r     <= 4'd0;
      plaintext_r <= 128'd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      data_r      <= data_next_s;
      key_r       <= key_next_s;
      mode_r      <= mode_next_s;
      round_r     <= round_next_s;
      plaintext_r <= plaintext_next_s;
      done_r      <= done_next_s;
      busy_r      <= busy_next_s;
    end
  end

  assign plaintext    = plaintext_r;
  assign decrypt_done = done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_crypto_decrypt_host.sv
// Self-checking bench for crypto_decrypt_host. Two instances (R=16 and R=1)
// share the stimulus. A cycle-level behavioural model predicts plaintext,
// done and busy for each instance. Plaintext values come from a loop-based
// forward/inverse cipher written directly from the round definition.
module tb_crypto_decrypt_host;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ciphertext = 128'd0;
  logic [127:0] key = 128'd0;
  logic [1:0]   crypto_mode = 2'd0;
  logic         decrypt_start = 1'b1;

  logic [127:0] pt0, pt1;
  logic         done0, done1, busy0, busy1;
  logic [127:0] pt_o [2];
  logic         done_o [2];
  logic         busy_o [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  crypto_decrypt_host #(.CRYPTO_ROUNDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .ciphertext(ciphertext), .key(key),
    .crypto_mode(crypto_mode), .decrypt_start(decrypt_start),
    .plaintext(pt0), .decrypt_done(done0), .busy(busy0)
  );

  crypto_decrypt_host #(.CRYPTO_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .ciphertext(ciphertext), .key(key),
    .crypto_mode(crypto_mode), .decrypt_start(decrypt_start),
    .plaintext(pt1), .decrypt_done(done1), .busy(busy1)
  );

  always_comb begin
    pt_o[0] = pt0;  pt_o[1] = pt1;
    done_o[0] = done0; done_o[1] = done1;
    busy_o[0] = busy0; busy_o[1] = busy1;
  end

  // ---------------- reference cipher ----------------
  logic [3:0] sb_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic int rounds_of(input int k);
    return (k == 0) ? 16 : 1;
  endfunction

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int i);
    logic [127:0] pr;
    pr = {4{32'hF0123456}};
    return k ^ (pr >> (8 * i));
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] n);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < 16; j++) if (sb_tab[j] == n) r = 4'(j);
    return r;
  endfunction

  function automatic logic [127:0] fwd_cipher(input logic [127:0] pt, input logic [127:0] k,
                                              input logic [1:0] m, input int rounds);
    logic [127:0] s, r;
    s = pt;
    for (int i = 0; i < rounds; i++) begin
      r = model_rk(k, i);
      s = s ^ r;
      s[7:0] = {sb_tab[s[7:4]], sb_tab[s[3:0]]};
      case (m)
        2'd0:    s = s ^ {112'd0, r[15:0]};
        2'd1:    s = {s[126:0], s[127]};
        2'd2:    s = s + 128'h9E37;
        default: s = ~s;
      endcase
    end
    return s ^ model_rk(k, 15);
  endfunction

  function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [127:0] k,
                                              input logic [1:0] m, input int rounds);
    logic [127:0] s, r;
    s = ct ^ model_rk(k, 15);
    for (int i = rounds - 1; i >= 0; i--) begin
      r = model_rk(k, i);
      case (m)
        2'd0:    s = s ^ {112'd0, r[15:0]};
        2'd1:    s = {s[0], s[127:1]};
        2'd2:    s = s - 128'h9E37;
        default: s = ~s;
      endcase
      s[7:0] = {isb(s[7:4]), isb(s[3:0])};
      s = s ^ r;
    end
    return s;
  endfunction

  // ---------------- cycle-level behaviour model ----------------
  int           m_remaining [2] = '{0, 0};
  logic         m_inflight  [2] = '{1'b0, 1'b0};
  logic [127:0] m_result    [2] = '{128'd0, 128'd0};
  logic [127:0] exp_pt      [2] = '{128'd0, 128'd0};
  logic         exp_done    [2] = '{1'b0, 1'b0};
  logic         exp_busy    [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_inflight[k] <= 1'b0;
        exp_pt[k]     <= 128'd0;
        exp_done[k]   <= 1'b0;
        exp_busy[k]   <= 1'b0;
      end else if (m_inflight[k]) begin
        m_remaining[k] <= m_remaining[k] - 1;
        if (m_remaining[k] == 1) begin
          exp_done[k]   <= 1'b1;
          exp_pt[k]     <= m_result[k];
          m_inflight[k] <= 1'b0;
        end else begin
          exp_done[k]   <= 1'b0;
        end
      end else begin
        exp_done[k] <= 1'b0;
        if (decrypt_start) begin
          m_inflight[k]  <= 1'b1;
          m_remaining[k] <= 3 * rounds_of(k);
          m_result[k]    <= inv_cipher(ciphertext, key, crypto_mode, rounds_of(k));
          exp_busy[k]    <= 1'b1;
        end else begin
          exp_busy[k]    <= 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [1:0] m);
    ciphertext = ct; key = k; crypto_mode = m; decrypt_start = 1'b1;
    @(posedge clk); #1;
    decrypt_start = 1'b0;
  endtask

  // Count edges after acceptance until done shows. Returns bound+1 on timeout.
  task automatic await_done(input int idx, input int bound, output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (done_o[idx]) break;
      if (lat > bound) break;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy_o[0] && !busy_o[1] && !done_o[0] && !done_o[1]) break;
    end
    check("settle_idle", {126'd0, busy_o[0], busy_o[1]}, 128'd0);
  endtask

  // ---------------- stimulus and checking ----------------
  initial begin
    fork
      begin : cmp_loop
        forever begin
          @(negedge clk);
          if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
              check($sformatf("cyc_pt[%0d]", k), pt_o[k], exp_pt[k]);
              check($sformatf("cyc_done[%0d]", k), {127'd0, done_o[k]}, {127'd0, exp_done[k]});
              check($sformatf("cyc_busy[%0d]", k), {127'd0, busy_o[k]}, {127'd0, exp_busy[k]});
            end
          end
        end
      end
      begin : stim
        int lat, nd, d_first, d_second;
        logic [127:0] p, k, c;
        logic [1:0]   m;

        // Model pins (hand-computed).
        check("pin_fwd_r1", fwd_cipher(128'd0, 128'd0, 2'd3, 1),
              128'h0FEDCBA90FEDCBA90FEDCBA90FEDCB05);
        check("pin_inv_r1", inv_cipher(128'd0, 128'd0, 2'd3, 1),
              128'h0FEDCBA90FEDCBA90FEDCBA90FEDCB0C);
        for (int mm = 0; mm < 4; mm++) begin
          p = rnd128(); k = rnd128();
          check("pin_roundtrip", inv_cipher(fwd_cipher(p, k, 2'(mm), 16), k, 2'(mm), 16), p);
        end

        // 1: reset held two cycles with start high.
        ciphertext = rnd128(); key = rnd128();
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
          check("rst_pt", pt_o[i], 128'd0);
          check("rst_done_busy", {126'd0, done_o[i], busy_o[i]}, 128'd0);
        end
        rst = 1'b0; decrypt_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_accept", {127'd0, busy_o[0]}, 128'd0);

        // 2: R=1 known answer.
        issue(128'd0, 128'd0, 2'd3);
        await_done(1, 10, lat);
        check("r1_latency", 128'(lat), 128'd3);
        check("r1_pt", pt_o[1], 128'h0FEDCBA90FEDCBA90FEDCBA90FEDCB0C);
        settle();

        // 3: every mode, random blocks, R=16.
        for (int mm = 0; mm < 4; mm++) begin
          for (int it = 0; it < 2; it++) begin
            p = rnd128(); k = rnd128(); m = 2'(mm);
            c = fwd_cipher(p, k, m, 16);
            issue(c, k, m);
            await_done(0, 100, lat);
            check($sformatf("mode%0d_latency", mm), 128'(lat), 128'd48);
            check($sformatf("mode%0d_pt", mm), pt_o[0], p);
            settle();
          end
        end

        // 4: start held high continuously, back-to-back issue.
        p = rnd128(); k = rnd128(); m = 2'($urandom_range(0, 3));
        ciphertext = fwd_cipher(p, k, m, 16); key = k; crypto_mode = m;
        decrypt_start = 1'b1;
        @(posedge clk); #1;
        nd = 0; d_first = -1; d_second = -1;
        for (int n = 1; n <= 97; n++) begin
          @(posedge clk); #1;
          if (done_o[0]) begin
            nd++;
            if (d_first < 0) d_first = n; else d_second = n;
          end
        end
        decrypt_start = 1'b0;
        check("b2b_first_done", 128'(d_first), 128'd48);
        check("b2b_second_done", 128'(d_second), 128'd97);
        check("b2b_done_count", 128'(nd), 128'd2);
        check("b2b_pt", pt_o[0], p);
        settle();

        // 5: inputs change right after acceptance.
        p = rnd128(); k = rnd128(); m = 2'($urandom_range(0, 3));
        issue(fwd_cipher(p, k, m, 16), k, m);
        ciphertext = rnd128(); key = rnd128(); crypto_mode = ~m;
        await_done(0, 100, lat);
        check("late_change_latency", 128'(lat), 128'd48);
        check("late_change_pt", pt_o[0], p);
        settle();

        // 6: reset during round 7, then a fresh block.
        issue(rnd128(), rnd128(), 2'($urandom_range(0, 3)));
        repeat (25) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {126'd0, busy_o[0], done_o[0]}, 128'd0);
        check("abort_pt", pt_o[0], 128'd0);
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 60; n++) begin
          @(posedge clk); #1;
          if (done_o[0] || busy_o[0]) nd++;
        end
        check("abort_quiet", 128'(nd), 128'd0);
        p = rnd128(); k = rnd128(); m = 2'($urandom_range(0, 3));
        issue(fwd_cipher(p, k, m, 16), k, m);
        await_done(0, 100, lat);
        check("post_abort_latency", 128'(lat), 128'd48);
        check("post_abort_pt", pt_o[0], p);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join
  end

endmodule
